// File: rtl/regfile_dump_pkg.sv
// Shared definitions for the register-file dump engine.
package regfile_dump_pkg;

  localparam int unsigned REG_IDX_W = 5;
  localparam int unsigned WORD_W    = 32;
  localparam logic [2:0]  HDR_PAD   = 3'b000;

  typedef enum logic [2:0] {
    StIdle,
    StLoad,
    StHdr,
    StData,
    StFin
  } dump_state_e;

endpackage

// File: rtl/regfile_dump_if.sv
// Byte stream (valid/ready) from the dump engine to the UART/display path.
interface regfile_dump_if;

  logic       out_valid;
  logic       out_ready;
  logic [7:0] out_data;

  modport master (
    output out_valid,
    output out_data,
    input  out_ready
  );

  modport slave (
    input  out_valid,
    input  out_data,
    output out_ready
  );

endinterface

// File: rtl/regfile_dump_byte_sel.sv
// Picks one byte of the shadowed word, most significant byte first.
module regfile_dump_byte_sel
  import regfile_dump_pkg::*;
(
  input  logic [WORD_W-1:0] word_i,
  input  logic [1:0]        sel_i,
  output logic [7:0]        byte_o
);

  // 4:1 byte mux, index 0 selects bits [31:24].
  always_comb begin
    byte_o = 8'h00;
    unique case (sel_i)
      2'd0: byte_o = word_i[31:24];
      2'd1: byte_o = word_i[23:16];
      2'd2: byte_o = word_i[15:8];
      2'd3: byte_o = word_i[7:0];
    endcase
  end

endmodule

// File: rtl/regfile_dump.sv
// Walks the register file debug port and streams each word as bytes.
module regfile_dump
  import regfile_dump_pkg::*;
#(
  parameter int unsigned FIRST_REG   = 0,
  parameter int unsigned LAST_REG    = 31,
  parameter bit          EMIT_HEADER = 1'b1
) (
  input  logic                 clk,
  input  logic                 clrn,
  input  logic                 start,
  output logic [REG_IDX_W-1:0] reg_addr,
  input  logic [WORD_W-1:0]    reg_out,
  regfile_dump_if.master       strm,
  output logic                 busy,
  output logic                 done
);

  localparam logic [REG_IDX_W-1:0] FirstIdx = REG_IDX_W'(FIRST_REG);
  localparam logic [REG_IDX_W-1:0] LastIdx  = REG_IDX_W'(LAST_REG);

  dump_state_e          state_q, state_d;
  logic [REG_IDX_W-1:0] addr_q, addr_d;
  logic [WORD_W-1:0]    shadow_q, shadow_d;
  logic [1:0]           cnt_q, cnt_d;
  logic [7:0]           data_byte;
  logic                 hs;

  assign hs = strm.out_valid && strm.out_ready;

  regfile_dump_byte_sel u_byte_sel (
    .word_i (shadow_q),
    .sel_i  (cnt_q),
    .byte_o (data_byte)
  );

  // State register with synchronous active-high clear.
  always_ff @(posedge clk) begin
    if (clrn) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Datapath registers: current index, word snapshot and byte position.
  always_ff @(posedge clk) begin
    if (clrn) begin
      addr_q   <= FirstIdx;
      shadow_q <= '0;
      cnt_q    <= 2'd0;
    end else begin
      addr_q   <= addr_d;
      shadow_q <= shadow_d;
      cnt_q    <= cnt_d;
    end
  end

  // Next-state and datapath update; every stall simply holds all registers.
  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    shadow_d = shadow_q;
    cnt_d    = cnt_q;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          state_d = StLoad;
          addr_d  = FirstIdx;
        end
      end
      StLoad: begin
        // Snapshot once so later regfile writes cannot tear this word.
        shadow_d = reg_out;
        cnt_d    = 2'd0;
        state_d  = EMIT_HEADER ? StHdr : StData;
      end
      StHdr: begin
        if (hs) begin
          state_d = StData;
        end
      end
      StData: begin
        if (hs) begin
          if (cnt_q == 2'd3) begin
            if (addr_q == LastIdx) begin
              state_d = StFin;
            end else begin
              addr_d  = addr_q + 1'b1;
              state_d = StLoad;
            end
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      StFin: begin
        addr_d  = FirstIdx;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // Outputs decoded from the current state.
  always_comb begin
    strm.out_valid = 1'b0;
    strm.out_data  = 8'h00;
    busy           = 1'b0;
    done           = 1'b0;
    unique case (state_q)
      StIdle: ;
      StLoad: busy = 1'b1;
      StHdr: begin
        busy           = 1'b1;
        strm.out_valid = 1'b1;
        strm.out_data  = {HDR_PAD, addr_q};
      end
      StData: begin
        busy           = 1'b1;
        strm.out_valid = 1'b1;
        strm.out_data  = data_byte;
      end
      StFin: done = 1'b1;
      default: ;
    endcase
  end

  assign reg_addr = addr_q;

endmodule

// File: tb/tb_regfile_dump.sv
// Randomized bench for regfile_dump with a byte-queue reference model.
module tb_regfile_dump;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        clrn, start_a, start_b;
  logic [4:0]  addr_a, addr_b;
  logic [31:0] rdata_a, rdata_b;
  logic        busy_a, done_a, busy_b, done_b;
  logic [31:0] rf [32];

  regfile_dump_if sa ();
  regfile_dump_if sb ();

  // Register file model: r0 hard-wired to zero.
  assign rdata_a = (addr_a == 5'd0) ? 32'h0 : rf[addr_a];
  assign rdata_b = (addr_b == 5'd0) ? 32'h0 : rf[addr_b];

  regfile_dump #(
    .FIRST_REG   (0),
    .LAST_REG    (31),
    .EMIT_HEADER (1'b1)
  ) u_dut_a (
    .clk      (clk),
    .clrn     (clrn),
    .start    (start_a),
    .reg_addr (addr_a),
    .reg_out  (rdata_a),
    .strm     (sa),
    .busy     (busy_a),
    .done     (done_a)
  );

  regfile_dump #(
    .FIRST_REG   (5),
    .LAST_REG    (5),
    .EMIT_HEADER (1'b0)
  ) u_dut_b (
    .clk      (clk),
    .clrn     (clrn),
    .start    (start_b),
    .reg_addr (addr_b),
    .reg_out  (rdata_b),
    .strm     (sb),
    .busy     (busy_b),
    .done     (done_b)
  );

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  // Reference model: expected bytes, bit 8 marks the last byte of a register.
  logic [8:0] exp_q [$];
  bit         m_active = 1'b0;
  bit         m_fin    = 1'b0;
  bit         m_gap    = 1'b0;

  logic [7:0] cap_q [$];
  logic [7:0] cap_b [$];
  logic [7:0] ref_q [$];
  int done_cnt = 0, done_cyc = 0, rise_cyc = 0;
  int done_b_cnt = 0, done_b_cyc = 0;
  bit busy_prev = 1'b0;

  logic [7:0] head_exp [10] = '{8'h00, 8'h00, 8'h00, 8'h00, 8'h00,
                                8'h01, 8'h11, 8'h22, 8'h33, 8'h44};
  logic [7:0] tail_exp [5]  = '{8'h1F, 8'hDE, 8'hAD, 8'hBE, 8'hEF};

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Model update and stream capture at each rising edge (pre-edge values).
  initial begin
    logic [31:0] w;
    logic [8:0]  item;
    forever begin
      @(posedge clk);
      cyc++;
      if (!clrn && sa.out_valid && sa.out_ready) cap_q.push_back(sa.out_data);
      if (!clrn && sb.out_valid && sb.out_ready) cap_b.push_back(sb.out_data);
      if (clrn) begin
        m_active = 1'b0;
        m_fin    = 1'b0;
        m_gap    = 1'b0;
        exp_q.delete();
      end else if (m_fin) begin
        m_fin = 1'b0;
      end else if (!m_active) begin
        if (start_a) begin
          m_active = 1'b1;
          m_gap    = 1'b1;
          for (int r = 0; r < 32; r++) begin
            w = (r == 0) ? 32'h0 : rf[r];
            exp_q.push_back({1'b0, 3'b000, 5'(r)});
            for (int b = 3; b >= 0; b--) exp_q.push_back({(b == 0), w[8*b +: 8]});
          end
        end
      end else if (m_gap) begin
        m_gap = 1'b0;
      end else if (sa.out_ready) begin
        item = exp_q.pop_front();
        if (exp_q.size() == 0) begin
          m_active = 1'b0;
          m_fin    = 1'b1;
        end else if (item[8]) begin
          m_gap = 1'b1;
        end
      end
    end
  end

  // Per-cycle compare against the model, sampled mid-cycle.
  initial begin
    forever begin
      @(negedge clk);
      if (busy_a && !busy_prev) rise_cyc = cyc;
      busy_prev = busy_a;
      if (done_a) begin
        done_cnt++;
        done_cyc = cyc;
      end
      if (done_b) begin
        done_b_cnt++;
        done_b_cyc = cyc;
      end
      check("valid", {31'b0, sa.out_valid}, {31'b0, m_active && !m_gap});
      if (m_active && !m_gap && exp_q.size() > 0) check("data", {24'b0, sa.out_data},
                                                        {24'b0, exp_q[0][7:0]});
      check("busy", {31'b0, busy_a}, {31'b0, m_active});
      check("done", {31'b0, done_a}, {31'b0, m_fin});
      if (!m_active && !m_fin) check("idle_addr", {27'b0, addr_a}, 32'd0);
    end
  end

  task automatic wait_done(input int base, input int budget, input string name);
    int n = 0;
    while (done_cnt == base && n < budget) begin
      tick;
      n++;
    end
    if (done_cnt == base) begin
      total++;
      bad++;
      $display("FAIL %s: timeout after %0d cycles, done not seen", name, budget);
    end
  endtask

  task automatic check_ref(input string name);
    int diffs = 0;
    for (int i = 0; i < 160; i++) begin
      if (i >= cap_q.size() || i >= ref_q.size() || cap_q[i] !== ref_q[i]) diffs++;
    end
    check({name, "_len"}, cap_q.size(), 160);
    check({name, "_diffs"}, diffs, 0);
  endtask

  initial begin
    int base, n, sb_cyc;
    bit pulsed;
    clrn         = 1'b1;
    start_a      = 1'b0;
    start_b      = 1'b0;
    sa.out_ready = 1'b1;
    sb.out_ready = 1'b1;
    for (int i = 0; i < 32; i++) rf[i] = $urandom;
    rf[1]  = 32'h11223344;
    rf[2]  = 32'h01020304;
    rf[5]  = 32'hA5A55A5A;
    rf[31] = 32'hDEADBEEF;

    // Reset, then idle for 50 cycles.
    repeat (2) tick;
    check("rst_valid", {31'b0, sa.out_valid}, 32'd0);
    check("rst_busy", {31'b0, busy_a}, 32'd0);
    check("rst_done", {31'b0, done_a}, 32'd0);
    check("rst_addr", {27'b0, addr_a}, 32'd0);
    check("rst_data", {24'b0, sa.out_data}, 32'd0);
    clrn = 1'b0;
    repeat (50) tick;
    check("idle_no_bytes", cap_q.size(), 0);

    // Full dump, consumer always ready.
    cap_q.delete();
    base = done_cnt;
    start_a = 1'b1;
    tick;
    start_a = 1'b0;
    wait_done(base, 1000, "full_done");
    repeat (5) tick;
    check("full_len", cap_q.size(), 160);
    for (int i = 0; i < 10; i++) check("full_head", {24'b0, cap_q[i]}, {24'b0, head_exp[i]});
    for (int i = 0; i < 5; i++) check("full_tail", {24'b0, cap_q[155+i]}, {24'b0, tail_exp[i]});
    check("full_done_once", done_cnt - base, 1);
    check("full_done_latency", done_cyc - rise_cyc, 192);
    ref_q = cap_q;

    // Random backpressure must not change the stream.
    cap_q.delete();
    base = done_cnt;
    start_a = 1'b1;
    tick;
    start_a = 1'b0;
    n = 0;
    while (done_cnt == base && n < 3000) begin
      sa.out_ready = 1'($urandom_range(0, 1));
      tick;
      n++;
    end
    sa.out_ready = 1'b1;
    check("bp_timeout", {31'b0, done_cnt == base}, 32'd0);
    repeat (3) tick;
    check_ref("bp");

    // Overwrite r2 while its header is stalled: old snapshot must go out.
    cap_q.delete();
    base = done_cnt;
    start_a = 1'b1;
    tick;
    start_a = 1'b0;
    n = 0;
    pulsed = 1'b0;
    while (done_cnt == base && n < 1000) begin
      if (!pulsed && cap_q.size() == 10 && sa.out_valid) begin
        pulsed       = 1'b1;
        sa.out_ready = 1'b0;
        tick;
        rf[2] = 32'hCAFEF00D;
        repeat (3) tick;
        sa.out_ready = 1'b1;
      end
      tick;
      n++;
    end
    check("tear_timeout", {31'b0, done_cnt == base}, 32'd0);
    check("tear_stalled", {31'b0, pulsed}, 32'd1);
    check("tear_hdr", {24'b0, cap_q[10]}, 32'h02);
    check("tear_word", {cap_q[11], cap_q[12], cap_q[13], cap_q[14]}, 32'h01020304);
    rf[2] = 32'h01020304;
    repeat (3) tick;

    // Start pulse mid-dump is ignored.
    cap_q.delete();
    base = done_cnt;
    start_a = 1'b1;
    tick;
    start_a = 1'b0;
    n = 0;
    pulsed = 1'b0;
    while (done_cnt == base && n < 1000) begin
      start_a = (!pulsed && cap_q.size() == 20);
      if (start_a) pulsed = 1'b1;
      tick;
      n++;
    end
    start_a = 1'b0;
    check("busy_start_timeout", {31'b0, done_cnt == base}, 32'd0);
    repeat (5) tick;
    check("busy_start_once", done_cnt - base, 1);
    check_ref("busy_start");

    // Clear at byte 40: stream abandoned, no done, then a fresh dump.
    cap_q.delete();
    base = done_cnt;
    start_a = 1'b1;
    tick;
    start_a = 1'b0;
    n = 0;
    while (cap_q.size() < 40 && n < 1000) begin
      tick;
      n++;
    end
    clrn = 1'b1;
    tick;
    clrn = 1'b0;
    check("clr_valid", {31'b0, sa.out_valid}, 32'd0);
    check("clr_busy", {31'b0, busy_a}, 32'd0);
    repeat (20) tick;
    check("clr_no_done", done_cnt - base, 0);
    check("clr_len", cap_q.size(), 40);
    cap_q.delete();
    start_a = 1'b1;
    tick;
    start_a = 1'b0;
    wait_done(base, 1000, "clr_restart_done");
    repeat (3) tick;
    check_ref("clr_restart");

    // Single register, no header.
    cap_b.delete();
    start_b = 1'b1;
    sb_cyc  = cyc;
    tick;
    start_b = 1'b0;
    n = 0;
    while (done_b_cnt == 0 && n < 100) begin
      tick;
      n++;
    end
    repeat (3) tick;
    check("nohdr_done_once", done_b_cnt, 1);
    check("nohdr_len", cap_b.size(), 4);
    check("nohdr_word", {cap_b[0], cap_b[1], cap_b[2], cap_b[3]}, 32'hA5A55A5A);
    check("nohdr_latency", done_b_cyc - sb_cyc, 6);
    check("nohdr_idle_busy", {31'b0, busy_b}, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
